uart_tx: RTL
============

# uart_tx

Asynchronous serial transmitter, the transmit half of the UART alongside the existing receiver. It serializes one DATA_BITS-wide word per request into a standard frame: start bit, data LSB first, optional parity, stop bit. Bit timing is paced by the shared oversampling tick `s_tick` from the baud-rate generator, so transmitter and receiver run from the same tick source.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `SB_TICKS`, 16: `s_tick` pulses per bit period. Applies to the start, data, parity and stop bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when `UART_TX_PARITY_EN` is defined.

- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `s_tick` input, 1 bit: one-`clk` oversampling strobe.
- `tx_start` input, 1 bit: transmit request, sampled in IDLE only.
- `din` input, DATA_BITS bits: word to send, captured when the request is accepted.
- `tx` output, 1 bit: serial line, registered, idle high.
- `tx_done_tick` output, 1 bit: one-`clk` pulse at the end of the stop bit.
- `tx_busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Registers:**
  - `state_reg`
  - tick counter `s_reg`, width clog2(SB_TICKS)
  - bit counter `n_reg`, width clog2(DATA_BITS)
  - shift register `b_reg`, DATA_BITS wide
  - `tx_reg`, which drives `tx`
  - `par_reg`, present only with the macro
- **Structure:** two-process FSM. A registered process resets asynchronously; a combinational next-state process assigns defaults first.
- **IDLE:**
  - `tx_next`=1.
  - On `tx_start`=1: `b_next`=`din`, `s_next`=0, `n_next`=0, go to START.
  - With the macro, also latch the parity: `par_next` = `^din` XOR PARITY_ODD.
- **START:**
  - `tx_next`=0.
  - On `s_tick` with `s_reg`==SB_TICKS-1: `s_next`=0, go to DATA.
  - On any other `s_tick`: `s_reg`+1.
- **DATA:**
  - `tx_next` = `b_reg[0]`.
  - On `s_tick` with `s_reg`==SB_TICKS-1: `s_next`=0, `b_next` = `b_reg` >> 1.
  - At that point, if `n_reg`==DATA_BITS-1, go to PARITY (macro) or STOP (no macro); otherwise `n_reg`+1.
- **PARITY** (macro only):
  - `tx_next` = `par_reg`.
  - After SB_TICKS ticks, `s_next`=0 and go to STOP.
- **STOP:**
  - `tx_next`=1.
  - On `s_tick` with `s_reg`==SB_TICKS-1: `tx_done_tick`=1, go to IDLE.
- **Requests and inputs:**
  - `tx_start` outside IDLE is ignored, with no queuing.
  - Changes to `din` after acceptance have no effect on the frame in flight.
- **Counters:** no counter is allowed to wrap. Every state exits at its terminal count.
- **Ticks outside IDLE:** `s_tick` has no effect in IDLE. In other states, `clk` cycles without `s_tick` hold all registers.

## Timing
- **Reset values:**
  - `tx`=1, `tx_done_tick`=0, `tx_busy`=0.
  - State IDLE, all counters 0.
  - Reset takes effect immediately, even mid-frame.
- **Start latency:** with `tx_start` high in cycle N, `tx` falls after the edge ending cycle N. `tx_busy` rises at the same edge.
- **Bit length:** each bit lasts exactly SB_TICKS `s_tick` pulses. Edges on `tx` are aligned one `clk` after the terminal tick, due to `tx_reg`.
- **Frame length:**
  - (1 + DATA_BITS + 1) × SB_TICKS ticks without the macro.
  - One extra bit period with the macro.
- **End of frame:**
  - `tx_done_tick` is combinational and high for exactly one `clk`, in the cycle of the last stop tick.
  - `tx_busy` falls at the next edge.
- **Back-to-back frames:**
  - `tx_start` is accepted in the first IDLE cycle after `tx_done_tick`.
  - The minimum inter-frame idle is 1 `clk`; the stop bit is never shortened.
- **Simultaneous `tx_start` and `tx_done_tick`:** the request is ignored because the state is still STOP.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - Adds the PARITY state and `par_reg`.
  - Frame becomes start, data, parity, stop.
  - Parity is even (`PARITY_ODD`=0) or odd (`PARITY_ODD`=1) over `din`.
- **`UART_TX_PARITY_EN` undefined:**
  - No parity logic.
  - DATA goes directly to STOP.
  - `PARITY_ODD` is unused.

## Test plan
- **Bench setup:** DATA_BITS=8, SB_TICKS=16, `s_tick` every 4 `clk`.
- **Reset:** assert `reset` for 3 cycles -> `tx`=1, `tx_busy`=0, `tx_done_tick`=0; `s_tick` alone produces no activity.
- **Basic frame:** send `din`=0xA5 without the macro -> `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks (64 `clk`). Exactly one `tx_done_tick` after 160 ticks. Loopback into `uart_rx` gives `dout`=0xA5 with one `rx_done_tick`.
- **Ignored request:** pulse `tx_start` with `din`=0xFF during frame 0x3C -> line carries only 0x3C; no second `tx_done_tick`.
- **Back-to-back:** frames 0x00 then 0xFF, with `tx_start` raised the cycle after `tx_done_tick` -> both frames correct; the stop bit is a full 16 ticks; `tx` stays high 1 `clk` between frames.
- **Mid-frame reset:** reset during data bit 3 of 0x81 -> `tx`=1 in the same cycle, `tx_busy`=0. A following 0x3C frame is sent correctly.
- **Parity:** with `UART_TX_PARITY_EN` and `PARITY_ODD`=0, send 0x07 -> parity bit 1, frame 176 ticks. With `PARITY_ODD`=1, send 0x07 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, stop bit.
// Bit timing is paced by the shared oversampling strobe s_tick, SB_TICKS strobes per bit.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit (even/odd via PARITY_ODD).
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned SB_TICKS   = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_done_tick,
    output logic                 tx_busy
);

    localparam int unsigned S_W = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
    localparam int unsigned N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    // PARITY_ODD selects a single bit of behaviour; reject anything else at elaboration
    if (PARITY_ODD > 1) begin : g_bad_parity_cfg
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e                 state_q, state_d;
    logic [S_W-1:0]         s_q, s_d;
    logic [N_W-1:0]         n_q, n_d;
    logic [DATA_BITS-1:0]   b_q, b_d;
    logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d follows the upcoming state so line edges land one clk after the terminal tick
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^din) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d          = '0;
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule
